// File: rtl/device_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : device_bus_initiator
// Brief    : Queued host-side initiator for the simple device bus; one
//            transaction outstanding, timeout-to-error, stray rvalid flag.
// Revision : 1.0 - initial release
// ============================================================================
module device_bus_initiator #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned CmdDepth      = 4,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 device_req_o,
    output logic [AddrWidth-1:0] device_addr_o,
    output logic                 device_we_o,
    output logic [3:0]           device_be_o,
    output logic [DataWidth-1:0] device_wdata_o,
    input  logic                 device_rvalid_i,
    input  logic [DataWidth-1:0] device_rdata_i,
    output logic                 busy_o,
    output logic                 stray_o
);
    localparam int unsigned PTR_W = $clog2(CmdDepth);
    localparam int unsigned TMR_W = $clog2(TimeoutCycles);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TimeoutCycles - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(CmdDepth);

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [3:0]           be;
        logic [DataWidth-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    cmd_t                 fifo_mem [CmdDepth];
    cmd_t                 cmd_in;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    cmd_t                 dev_q, dev_d;
    logic                 req_q, req_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 stray_q, stray_d;
    logic                 fifo_full, fifo_empty, push, pop;

    assign cmd_in     = {cmd_we_i, cmd_addr_i, cmd_be_i, cmd_wdata_i};
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = cmd_valid_i && !fifo_full;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        dev_d       = dev_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (device_rvalid_i) begin
                    rsp_rdata_d = dev_q.we ? '0 : device_rdata_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RSP;
                end else if (timer_q == TMR_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            dev_d = fifo_mem[rd_ptr_q];
        end

        req_d       = (state_d == ST_REQ);
        rsp_valid_d = (state_d == ST_RSP);
        stray_d     = stray_q || (device_rvalid_i && (state_q != ST_WAIT));

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            dev_q       <= '0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            stray_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dev_q       <= dev_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            stray_q     <= stray_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign cmd_ready_o    = !fifo_full;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign device_req_o   = req_q;
    assign device_addr_o  = dev_q.addr;
    assign device_we_o    = dev_q.we;
    assign device_be_o    = dev_q.be;
    assign device_wdata_o = dev_q.wdata;
    assign busy_o         = (state_q != ST_IDLE) || !fifo_empty;
    assign stray_o        = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_device_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_device_bus_initiator
// Brief    : Scoreboard bench: a 1-cycle device model, queued expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_device_bus_initiator;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        device_req_o, device_we_o, device_rvalid_i, busy_o, stray_o;
    logic [31:0] device_addr_o, device_wdata_o, device_rdata_i;
    logic [3:0]  device_be_o;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    cmd_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    int   n_vec = 0, n_err = 0, n_req = 0;
    int   stray_req = 0, stray_done = 0;
    bit   dev_silent = 1'b0, dev_pend = 1'b0;
    logic [31:0] dev_addr = '0;

    device_bus_initiator #(
        .AddrWidth(32), .DataWidth(32), .CmdDepth(4), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o),
        .device_we_o(device_we_o), .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o), .device_rvalid_i(device_rvalid_i),
        .device_rdata_i(device_rdata_i), .busy_o(busy_o), .stray_o(stray_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] dev_model(input logic [31:0] a);
        return a ^ 32'h0000_005E;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device model and response monitor, both evaluated mid-cycle.
    initial begin
        device_rvalid_i = 1'b0;
        device_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            device_rvalid_i = 1'b0;
            device_rdata_i  = '0;
            if (dev_pend) begin
                device_rvalid_i = 1'b1;
                device_rdata_i  = dev_model(dev_addr);
                dev_pend        = 1'b0;
            end else if (stray_done != stray_req) begin
                device_rvalid_i = 1'b1;
                device_rdata_i  = 32'hDEAD_BEEF;
                stray_done++;
            end
            if (device_req_o) begin
                cmd_t e;
                n_req++;
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_req_q.pop_front();
                    check("req_addr", {32'd0, device_addr_o}, {32'd0, e.addr});
                    check("req_we_be", {59'd0, device_we_o, device_be_o}, {59'd0, e.we, e.be});
                    check("req_wdata", {32'd0, device_wdata_o}, {32'd0, e.wdata});
                end
                if (!dev_silent) begin
                    dev_pend = 1'b1;
                    dev_addr = device_addr_o;
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_t r;
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, r.rdata});
                    check("rsp_err", {63'd0, rsp_err_o}, {63'd0, r.err});
                end
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, output bit acc);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_be_i    = be;
        cmd_wdata_i = wdata;
        @(negedge clk_i);
        acc = cmd_ready_o;
        if (acc) begin
            exp_req_q.push_back({we, addr, be, wdata});
            exp_rsp_q.push_back({(we || dev_silent) ? 32'd0 : dev_model(addr), dev_silent});
        end
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Negedges until rsp_valid_o, counting the pop cycle as 1.
    task automatic wait_rsp(output int k);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!rsp_valid_o && k < 100);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((exp_rsp_q.size() != 0 || busy_o) && k < 300) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check(tag, {63'd0, (k < 300)}, 64'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int k, acc_cnt, req0;
        logic [31:0] r0, a0;
        logic        e0, w0, stable;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", {63'd0, cmd_ready_o}, 64'd1);
        check("rst_outs", {59'd0, rsp_valid_o, device_req_o, busy_o, stray_o, rsp_err_o}, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single write on a one-cycle device.
        req0 = n_req;
        push_cmd(1'b1, 32'h0, 4'hF, 32'hA5, acc);
        check("t1_acc", {63'd0, acc}, 64'd1);
        wait_idle("t1_drain");
        check("t1_one_req", 64'(n_req - req0), 64'd1);

        // Read with latency check: pop counts as cycle 1, response in cycle 4.
        push_cmd(1'b0, 32'h4, 4'hF, 32'h0, acc);
        wait_rsp(k);
        check("t2_latency", 64'(k), 64'd4);
        wait_idle("t2_drain");

        // Silent device: 16 WAIT cycles then error; a late rvalid is stray.
        dev_silent = 1'b1;
        push_cmd(1'b0, 32'h8, 4'h3, 32'h0, acc);
        wait_rsp(k);
        check("t3_latency", 64'(k), 64'd19);
        wait_idle("t3_drain");
        check("t3_no_stray_yet", {63'd0, stray_o}, 64'd0);
        dev_silent = 1'b0;
        stray_req++;
        repeat (3) @(posedge clk_i);
        #1;
        check("t3_stray", {63'd0, stray_o}, 64'd1);

        // Backpressure: one in flight plus four queued.
        rsp_ready_i = 1'b0;
        req0    = n_req;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(i[0], 32'h100 + 32'(i) * 4, 4'(i + 1), 32'h1000 + 32'(i), acc);
            acc_cnt += int'(acc);
        end
        check("t4_accepted", 64'(acc_cnt), 64'd5);
        check("t4_ready_full", {63'd0, cmd_ready_o}, 64'd0);
        repeat (6) @(posedge clk_i);
        #1;
        check("t4_one_req", 64'(n_req - req0), 64'd1);
        check("t4_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);

        // Response held under backpressure, then back-to-back REQ.
        @(negedge clk_i);
        r0 = rsp_rdata_o; e0 = rsp_err_o; a0 = device_addr_o; w0 = device_we_o;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_rdata_o !== r0 || rsp_err_o !== e0 ||
                device_addr_o !== a0 || device_we_o !== w0 || device_req_o) stable = 1'b0;
        end
        check("t5_stable", {63'd0, stable}, 64'd1);
        check("t5_hold_rdata", {32'd0, r0}, {32'd0, dev_model(32'h100)});
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("t5_b2b_req", {63'd0, device_req_o}, 64'd1);
        wait_idle("t5_drain");
        check("t5_all_reqs", 64'(n_req - req0), 64'd5);

        // Reset in WAIT with a second command queued.
        dev_silent = 1'b1;
        @(posedge clk_i);
        #1;
        push_cmd(1'b0, 32'h200, 4'hF, 32'h0, acc);
        push_cmd(1'b1, 32'h204, 4'hF, 32'h77, acc);
        @(posedge clk_i);
        #1;
        check("t6_busy_before", {63'd0, busy_o}, 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_async", {61'd0, device_req_o, rsp_valid_o, busy_o}, 64'd0);
        exp_req_q.delete();
        exp_rsp_q.delete();
        dev_silent = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("t6_after_rst", {61'd0, cmd_ready_o, stray_o, busy_o}, 64'd4);

        // Recovery after reset.
        push_cmd(1'b0, 32'h30, 4'hF, 32'h0, acc);
        wait_idle("t7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
